// File: rtl/alu_console_pkg.sv
// Shared definitions for the ALU console: field selects, FSM states,
// display row numbers and the ASCII row names (right-aligned in 40 bits).
package alu_console_pkg;

  localparam logic [2:0] SEL_OP1  = 3'd0;
  localparam logic [2:0] SEL_OP2  = 3'd1;
  localparam logic [2:0] SEL_F    = 3'd2;
  localparam logic [2:0] SEL_DIR  = 3'd3;
  localparam logic [2:0] SEL_BITE = 3'd4;
  localparam logic [2:0] SEL_CI   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [5:0] ROW_OP1  = 6'd1;
  localparam logic [5:0] ROW_OP2  = 6'd2;
  localparam logic [5:0] ROW_CI   = 6'd3;
  localparam logic [5:0] ROW_F    = 6'd4;
  localparam logic [5:0] ROW_DIR  = 6'd5;
  localparam logic [5:0] ROW_BITE = 6'd6;
  localparam logic [5:0] ROW_OUT  = 6'd7;
  localparam logic [5:0] ROW_CO   = 6'd8;
  localparam logic [5:0] ROW_CNT  = 6'd9;
  localparam logic [5:0] ROW_HIST = 6'd10;

  localparam logic [39:0] NAME_OP1  = {16'h0, 24'h4F5031};   // "OP1"
  localparam logic [39:0] NAME_OP2  = {16'h0, 24'h4F5032};   // "OP2"
  localparam logic [39:0] NAME_CI   = {24'h0, 16'h4349};     // "CI"
  localparam logic [39:0] NAME_F    = {32'h0, 8'h46};        // "F"
  localparam logic [39:0] NAME_DIR  = {16'h0, 24'h444952};   // "DIR"
  localparam logic [39:0] NAME_BITE = {8'h0, 32'h42495445};  // "BITE"
  localparam logic [39:0] NAME_OUT  = {16'h0, 24'h4F5554};   // "OUT"
  localparam logic [39:0] NAME_CO   = {24'h0, 16'h434F};     // "CO"
  localparam logic [39:0] NAME_CNT  = {16'h0, 24'h434E54};   // "CNT"

  // "Hk": 'H' followed by the ASCII digit k (k < 8, so '0' | k)
  function automatic logic [39:0] hist_name(input logic [2:0] k);
    return {24'h0, 8'h48, 5'b00110, k};
  endfunction

endpackage

// File: rtl/alu_console_hist_ring.sv
// Result history ring: one write port, saturating entry count, and a
// read port addressed relative to the newest entry (index 0 = newest).
module alu_hist_ring
  import alu_console_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH:0]   wr_data,
  input  logic [2:0]       rd_idx,
  output logic [WIDTH:0]   rd_data,
  output logic [3:0]       count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_addr;

  // Write newest entry, advance pointer (wraps naturally), saturate count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + PW'(1);
      if (count != 4'(DEPTH)) count <= count + 4'd1;
    end
  end

  // Newest lives one slot behind the write pointer; DEPTH is a power of two
  always_comb begin
    rd_addr = PW'(4'(wr_ptr) - 4'd1 - 4'(rd_idx));
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/alu_console.sv
// ALU console: operand/control fields loaded by strobed writes, one ALU
// operation per exec_req with timeout, result history and LCD row readout.
// Handshake: input_valid and exec_req are single-cycle strobes sampled
// only in IDLE; alu_start pulses for the ISSUE cycle; alu_done is a
// single-cycle strobe honoured only in WAIT (no backpressure anywhere).
module alu_console
  import alu_console_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int HIST_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  input  logic [2:0]       input_sel,
  input  logic [31:0]      input_value,
  input  logic             exec_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  output logic [1:0]       alu_dir,
  output logic [4:0]       alu_bite,
  output logic             alu_ci,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_co,
  output logic             busy,
  output logic             err_timeout,
  input  logic [5:0]       display_number,
  output logic             display_valid,
  output logic [39:0]      display_name,
  output logic [31:0]      display_value,
  output logic [1:0]       state_dbg
);

  state_t           state, state_n;
  logic [WIDTH-1:0] op1, op2, op1_n, op2_n;
  logic [2:0]       f, f_n;
  logic [1:0]       dir, dir_n;
  logic [4:0]       bite, bite_n;
  logic             ci, ci_n;
  logic [15:0]      wait_cnt;
  logic [WIDTH-1:0] res_q;
  logic             co_q;
  logic             timeout_hit;
  logic [WIDTH:0]   rd_data;
  logic [3:0]       hist_count;
  logic [2:0]       rd_idx;
  logic [5:0]       hist_k;
  logic             dv_n;
  logic [39:0]      dn_n;
  logic [31:0]      dval_n;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; alu_done beats a coincident timeout
  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:   if (exec_req) state_n = ST_ISSUE;
      ST_ISSUE:  state_n = ST_WAIT;
      ST_WAIT: begin
        if (alu_done) begin
          state_n = ST_COMMIT;
        end else if (wait_cnt == 16'(TIMEOUT)) begin
          state_n     = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_COMMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state != ST_IDLE);
    alu_start = (state == ST_ISSUE);
    state_dbg = state;
  end

  // Field update values; writes only land while idle
  always_comb begin
    op1_n  = op1;
    op2_n  = op2;
    f_n    = f;
    dir_n  = dir;
    bite_n = bite;
    ci_n   = ci;
    if (state == ST_IDLE && input_valid) begin
      case (input_sel)
        SEL_OP1:  op1_n  = input_value[WIDTH-1:0];
        SEL_OP2:  op2_n  = input_value[WIDTH-1:0];
        SEL_F:    f_n    = input_value[2:0];
        SEL_DIR:  dir_n  = input_value[1:0];
        SEL_BITE: bite_n = input_value[4:0];
        SEL_CI:   ci_n   = input_value[0];
        default:  ;
      endcase
    end
  end

  // Field registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op1 <= '0; op2 <= '0; f <= '0; dir <= '0; bite <= '0; ci <= 1'b0;
    end else begin
      op1 <= op1_n; op2 <= op2_n; f <= f_n; dir <= dir_n; bite <= bite_n; ci <= ci_n;
    end
  end

  // Snapshot takes the post-write field values so a same-cycle write is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a <= '0; alu_b <= '0; alu_f <= '0; alu_dir <= '0; alu_bite <= '0; alu_ci <= 1'b0;
    end else if (state == ST_IDLE && exec_req) begin
      alu_a <= op1_n; alu_b <= op2_n; alu_f <= f_n;
      alu_dir <= dir_n; alu_bite <= bite_n; alu_ci <= ci_n;
    end
  end

  // Wait counter reads 1 in the first WAIT cycle
  always_ff @(posedge clk) begin
    if (reset)                  wait_cnt <= '0;
    else if (state == ST_ISSUE) wait_cnt <= 16'd1;
    else if (state == ST_WAIT)  wait_cnt <= wait_cnt + 16'd1;
  end

  // Capture the ALU result and maintain the sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q       <= '0;
      co_q        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_WAIT && alu_done) begin
        res_q <= alu_result;
        co_q  <= alu_co;
      end
      if (timeout_hit)              err_timeout <= 1'b1;
      else if (state == ST_COMMIT)  err_timeout <= 1'b0;
    end
  end

  alu_hist_ring #(.WIDTH(WIDTH), .DEPTH(HIST_DEPTH)) u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (state == ST_COMMIT),
    .wr_data ({co_q, res_q}),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .count   (hist_count)
  );

  // Row decode; history rows beyond the live count read as invalid
  always_comb begin
    hist_k = display_number - ROW_HIST;
    rd_idx = (display_number >= ROW_HIST) ? 3'(hist_k) : 3'd0;
    dv_n   = 1'b0;
    dn_n   = '0;
    dval_n = '0;
    case (display_number)
      ROW_OP1:  begin dv_n = 1'b1; dn_n = NAME_OP1;  dval_n = 32'(op1);  end
      ROW_OP2:  begin dv_n = 1'b1; dn_n = NAME_OP2;  dval_n = 32'(op2);  end
      ROW_CI:   begin dv_n = 1'b1; dn_n = NAME_CI;   dval_n = 32'(ci);   end
      ROW_F:    begin dv_n = 1'b1; dn_n = NAME_F;    dval_n = 32'(f);    end
      ROW_DIR:  begin dv_n = 1'b1; dn_n = NAME_DIR;  dval_n = 32'(dir);  end
      ROW_BITE: begin dv_n = 1'b1; dn_n = NAME_BITE; dval_n = 32'(bite); end
      ROW_OUT: if (hist_count != 4'd0) begin
        dv_n = 1'b1; dn_n = NAME_OUT; dval_n = 32'(rd_data[WIDTH-1:0]);
      end
      ROW_CO: if (hist_count != 4'd0) begin
        dv_n = 1'b1; dn_n = NAME_CO; dval_n = 32'(rd_data[WIDTH]);
      end
      ROW_CNT:  begin dv_n = 1'b1; dn_n = NAME_CNT; dval_n = 32'(hist_count); end
      default: if (display_number >= ROW_HIST && hist_k < 6'(hist_count)) begin
        dv_n = 1'b1; dn_n = hist_name(3'(hist_k)); dval_n = 32'(rd_data[WIDTH-1:0]);
      end
    endcase
  end

  // Registered display response
  always_ff @(posedge clk) begin
    if (reset) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= dv_n;
      display_name  <= dn_n;
      display_value <= dval_n;
    end
  end

endmodule

// File: tb/tb_alu_console.sv
// Directed bench for alu_console (WIDTH 32, HIST_DEPTH 4, TIMEOUT 4).
module tb_alu_console;

  logic        clk = 1'b0;
  logic        reset;
  logic        input_valid;
  logic [2:0]  input_sel;
  logic [31:0] input_value;
  logic        exec_req;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_f;
  logic [1:0]  alu_dir;
  logic [4:0]  alu_bite;
  logic        alu_ci, alu_start;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        alu_co;
  logic        busy, err_timeout;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  alu_console #(.WIDTH(32), .HIST_DEPTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_sel(input_sel), .input_value(input_value),
    .exec_req(exec_req),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_dir(alu_dir),
    .alu_bite(alu_bite), .alu_ci(alu_ci), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_co(alu_co),
    .busy(busy), .err_timeout(err_timeout),
    .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value),
    .state_dbg(state_dbg)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ASCII string packed right-aligned, high bytes zero
  function automatic logic [63:0] nm(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r = (r << 8) | 64'(s[i]);
    return r;
  endfunction

  task automatic write_field(input logic [2:0] sel, input logic [31:0] val);
    input_valid = 1'b1;
    input_sel   = sel;
    input_value = val;
    tick();
    input_valid = 1'b0;
  endtask

  task automatic read_row(input int n, input logic ev, input logic [63:0] en, input logic [63:0] evl);
    display_number = 6'(n);
    tick();
    check($sformatf("row%0d_valid", n), 64'(display_valid), 64'(ev));
    check($sformatf("row%0d_name", n),  64'(display_name),  en);
    check($sformatf("row%0d_value", n), 64'(display_value), evl);
  endtask

  // One operation; alu_done arrives in the lat-th WAIT cycle
  task automatic run_op(input logic [31:0] res, input logic co, input int lat);
    exec_req = 1'b1;
    tick();
    exec_req = 1'b0;
    tick();
    repeat (lat - 1) tick();
    alu_done   = 1'b1;
    alu_result = res;
    alu_co     = co;
    tick();
    alu_done = 1'b0;
    tick();
    check("op_idle_busy", 64'(busy), 64'h0);
  endtask

  initial begin
    reset = 1'b1; input_valid = 1'b0; input_sel = '0; input_value = '0;
    exec_req = 1'b0; alu_done = 1'b0; alu_result = '0; alu_co = 1'b0;
    display_number = '0;

    // Reset state
    tick(); tick();
    check("rst_busy",  64'(busy), 64'h0);
    check("rst_err",   64'(err_timeout), 64'h0);
    check("rst_start", 64'(alu_start), 64'h0);
    check("rst_alu_a", 64'(alu_a), 64'h0);
    check("rst_state", 64'(state_dbg), 64'h0);
    check("rst_dvalid", 64'(display_valid), 64'h0);
    check("rst_dvalue", 64'(display_value), 64'h0);
    reset = 1'b0;

    // Field writes and basic rows
    write_field(3'd0, 32'h12);
    write_field(3'd1, 32'h34);
    write_field(3'd2, 32'h1);
    read_row(1, 1'b1, nm("OP1"), 64'h12);
    read_row(2, 1'b1, nm("OP2"), 64'h34);
    read_row(4, 1'b1, nm("F"), 64'h1);
    read_row(0, 1'b0, 64'h0, 64'h0);
    read_row(7, 1'b0, 64'h0, 64'h0);
    read_row(9, 1'b1, nm("CNT"), 64'h0);

    // First operation, done 2 cycles after alu_start
    exec_req = 1'b1;
    tick();
    exec_req = 1'b0;
    check("issue_start", 64'(alu_start), 64'h1);
    check("issue_a", 64'(alu_a), 64'h12);
    check("issue_b", 64'(alu_b), 64'h34);
    check("issue_f", 64'(alu_f), 64'h1);
    check("issue_busy", 64'(busy), 64'h1);
    check("issue_state", 64'(state_dbg), 64'h1);
    tick();
    check("wait_start", 64'(alu_start), 64'h0);
    check("wait_state", 64'(state_dbg), 64'h2);
    tick();
    alu_done = 1'b1; alu_result = 32'h46; alu_co = 1'b0;
    tick();
    alu_done = 1'b0;
    check("commit_state", 64'(state_dbg), 64'h3);
    check("commit_busy", 64'(busy), 64'h1);
    tick();
    check("turnaround_busy", 64'(busy), 64'h0);
    read_row(7, 1'b1, nm("OUT"), 64'h46);
    read_row(8, 1'b1, nm("CO"), 64'h0);
    read_row(9, 1'b1, nm("CNT"), 64'h1);

    // Five more results 1..5 overflow the 4-entry ring
    for (int i = 1; i <= 5; i++) run_op(32'(i), (i == 5), 1);
    read_row(9, 1'b1, nm("CNT"), 64'h4);
    read_row(10, 1'b1, nm("H0"), 64'h5);
    read_row(13, 1'b1, nm("H3"), 64'h2);
    read_row(14, 1'b0, 64'h0, 64'h0);
    read_row(8, 1'b1, nm("CO"), 64'h1);
    read_row(7, 1'b1, nm("OUT"), 64'h5);

    // Timeout with no alu_done
    exec_req = 1'b1;
    tick();
    exec_req = 1'b0;
    repeat (4) tick();
    check("to_wait4_busy", 64'(busy), 64'h1);
    check("to_wait4_state", 64'(state_dbg), 64'h2);
    tick();
    check("to_busy", 64'(busy), 64'h0);
    check("to_err", 64'(err_timeout), 64'h1);
    read_row(9, 1'b1, nm("CNT"), 64'h4);
    read_row(7, 1'b1, nm("OUT"), 64'h5);

    // Done on the same cycle the counter hits TIMEOUT: done wins, err clears
    run_op(32'h77, 1'b0, 4);
    check("done_wins_err", 64'(err_timeout), 64'h0);

    // alu_done while idle is ignored
    alu_done = 1'b1; alu_result = 32'hEE;
    tick();
    alu_done = 1'b0;
    tick();
    check("idle_done_state", 64'(state_dbg), 64'h0);
    read_row(7, 1'b1, nm("OUT"), 64'h77);
    read_row(10, 1'b1, nm("H0"), 64'h77);
    read_row(11, 1'b1, nm("H1"), 64'h5);
    read_row(9, 1'b1, nm("CNT"), 64'h4);

    // Truncating field writes; select 6 is ignored
    write_field(3'd2, 32'hF);
    write_field(3'd3, 32'h6);
    write_field(3'd4, 32'h3F);
    write_field(3'd5, 32'h3);
    write_field(3'd6, 32'hABCD);
    read_row(4, 1'b1, nm("F"), 64'h7);
    read_row(5, 1'b1, nm("DIR"), 64'h2);
    read_row(6, 1'b1, nm("BITE"), 64'h1F);
    read_row(3, 1'b1, nm("CI"), 64'h1);
    read_row(1, 1'b1, nm("OP1"), 64'h12);
    read_row(2, 1'b1, nm("OP2"), 64'h34);

    // Write coincident with exec_req lands first; writes while busy ignored
    input_valid = 1'b1; input_sel = 3'd1; input_value = 32'h99; exec_req = 1'b1;
    tick();
    input_valid = 1'b0; exec_req = 1'b0;
    check("same_b", 64'(alu_b), 64'h99);
    check("same_a", 64'(alu_a), 64'h12);
    check("same_f", 64'(alu_f), 64'h7);
    check("same_dir", 64'(alu_dir), 64'h2);
    check("same_bite", 64'(alu_bite), 64'h1F);
    check("same_ci", 64'(alu_ci), 64'h1);
    check("same_start", 64'(alu_start), 64'h1);
    tick();
    input_valid = 1'b1; input_sel = 3'd0; input_value = 32'hFF;
    tick();
    input_valid = 1'b0;
    check("busy_write_alu_a", 64'(alu_a), 64'h12);
    alu_done = 1'b1; alu_result = 32'h55; alu_co = 1'b1;
    tick();
    alu_done = 1'b0;
    tick();
    check("busy_write_idle", 64'(busy), 64'h0);
    read_row(1, 1'b1, nm("OP1"), 64'h12);
    read_row(2, 1'b1, nm("OP2"), 64'h99);
    read_row(7, 1'b1, nm("OUT"), 64'h55);

    // Reset during WAIT, then a stale alu_done
    exec_req = 1'b1;
    tick();
    exec_req = 1'b0;
    tick();
    check("pre_rst_state", 64'(state_dbg), 64'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state", 64'(state_dbg), 64'h0);
    alu_done = 1'b1; alu_result = 32'hAB;
    tick();
    alu_done = 1'b0;
    tick();
    check("post_rst_state", 64'(state_dbg), 64'h0);
    check("post_rst_busy", 64'(busy), 64'h0);
    check("post_rst_err", 64'(err_timeout), 64'h0);
    check("post_rst_alu_a", 64'(alu_a), 64'h0);
    read_row(9, 1'b1, nm("CNT"), 64'h0);
    read_row(7, 1'b0, 64'h0, 64'h0);
    read_row(1, 1'b1, nm("OP1"), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
